// File: rtl/partial_extract_stim_checker.sv
// partial_extract_stim_checker: vector FIFO driving a partial circuit, sampling and checking its outputs (PARTIAL_CHK_SIGNATURE_EN adds a MISR signature output)
module partial_extract_stim_checker #(
    parameter int DEPTH = 4,
    parameter int LAT   = 0,
    parameter int CNTW  = 8
) (
    input  logic            CLK,
    input  logic            ASYNCRESET,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_vec,
    input  logic [3:0]      in_exp,
    output logic [1:0]      I0,
    output logic [1:0]      I1,
    output logic            lifted_input0,
    output logic            lifted_input1,
    input  logic            O0,
    input  logic            O1,
    input  logic            O2,
    input  logic            O3,
    output logic            res_valid,
    output logic            res_fail,
    output logic [3:0]      res_obs,
    output logic [CNTW-1:0] fail_cnt,
    output logic            busy
`ifdef PARTIAL_CHK_SIGNATURE_EN
    ,
    output logic [15:0]     sig
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, APPLY, CAPTURE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      wait_q, wait_d;
    logic [5:0]      drv_q, drv_d;
    logic [3:0]      exp_q, exp_d;
    logic [3:0]      obs_q, obs_d;
    logic            fail_q, fail_d;
    logic [CNTW-1:0] fcnt_q, fcnt_d;
    logic [9:0]      mem_q [DEPTH];
    logic            push, launch, empty;
    logic [3:0]      o_now;
`ifdef PARTIAL_CHK_SIGNATURE_EN
    logic [15:0]     sig_q, sig_d;
`endif

    assign empty    = cnt_q == '0;
    assign in_ready = cnt_q != CW'(DEPTH);
    assign push     = in_valid && in_ready;
    // The result cycle (CAPTURE) can launch the next vector itself, giving LAT+2 cycles per vector
    assign launch   = !empty && (state_q == IDLE || state_q == CAPTURE);
    assign o_now    = {O3, O2, O1, O0};

    // FIFO pointers and occupancy; a same-cycle push and pop leave the count unchanged
    always_comb begin
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = launch ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(launch);
    end

    // Sequencer: launch a vector, wait LAT cycles, then sample and score the partial's outputs
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        drv_d   = drv_q;
        exp_d   = exp_q;
        obs_d   = obs_q;
        fail_d  = fail_q;
        fcnt_d  = fcnt_q;
`ifdef PARTIAL_CHK_SIGNATURE_EN
        sig_d   = sig_q;
`endif
        if (launch) begin
            state_d = APPLY;
            drv_d   = mem_q[rd_q][5:0];
            exp_d   = mem_q[rd_q][9:6];
            wait_d  = 4'(LAT);
        end else if (state_q == CAPTURE) begin
            state_d = IDLE;
        end else if (state_q == APPLY) begin
            if (wait_q == 4'd0) begin
                state_d = CAPTURE;
                obs_d   = o_now;
                fail_d  = o_now != exp_q;
                fcnt_d  = (o_now != exp_q && fcnt_q != '1) ? fcnt_q + CNTW'(1) : fcnt_q;
`ifdef PARTIAL_CHK_SIGNATURE_EN
                sig_d   = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ {12'h0, o_now};
`endif
            end else begin
                wait_d = wait_q - 4'd1;
            end
        end
    end

    // State registers; reset drops any vector in flight
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            drv_q   <= '0;
            exp_q   <= '0;
            obs_q   <= '0;
            fail_q  <= 1'b0;
            fcnt_q  <= '0;
`ifdef PARTIAL_CHK_SIGNATURE_EN
            sig_q   <= 16'hFFFF;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            drv_q   <= drv_d;
            exp_q   <= exp_d;
            obs_q   <= obs_d;
            fail_q  <= fail_d;
            fcnt_q  <= fcnt_d;
`ifdef PARTIAL_CHK_SIGNATURE_EN
            sig_q   <= sig_d;
`endif
        end
    end

    // FIFO storage holds {expected, vector}; contents are don't-care while empty
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q] <= {in_exp, in_vec};
    end

    assign I0            = drv_q[1:0];
    assign I1            = drv_q[3:2];
    assign lifted_input0 = drv_q[4];
    assign lifted_input1 = drv_q[5];
    assign res_valid     = state_q == CAPTURE;
    assign res_fail      = fail_q;
    assign res_obs       = obs_q;
    assign fail_cnt      = fcnt_q;
    assign busy          = state_q != IDLE || !empty;
`ifdef PARTIAL_CHK_SIGNATURE_EN
    assign sig           = sig_q;
`endif
endmodule
